tdoa_angle_est: RTL and testbench

- Sits directly downstream of the cross-correlation stage.
- Captures the winning lag index (`sequence_num`, 0..60) on each rising edge of that stage's `finished` level.
- Converts the index to a signed sample lag and smooths it with a power-of-two moving average.
- Maps the averaged lag to an arrival angle in degrees through an arcsine ROM, then issues a one-cycle `angle_valid` pulse.

---
 rtl/tdoa_angle_est_pkg.sv | 22 ++
 rtl/tdoa_angle_est_asin_rom.sv | 26 ++
 rtl/tdoa_angle_est.sv | 192 +++++++++++++++++++
 tb/tb_tdoa_angle_est.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdoa_angle_est_pkg.sv
// Shared constants, FSM state encoding and the arcsine table for the TDOA angle estimator.
// Table entry k is round(asin(k*343/(48000*0.25))) in degrees.
package tdoa_pkg;

    localparam int MAX_LAG = 30;
    localparam int SEQ_MAX = 60;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        LOOKUP = 2'd2,
        OUT    = 2'd3
    } state_e;

    localparam logic [6:0] ASIN_LUT [0:30] = '{
        7'd0,  7'd2,  7'd3,  7'd5,  7'd7,  7'd8,  7'd10, 7'd12,
        7'd13, 7'd15, 7'd17, 7'd18, 7'd20, 7'd22, 7'd24, 7'd25,
        7'd27, 7'd29, 7'd31, 7'd33, 7'd35, 7'd37, 7'd39, 7'd41,
        7'd43, 7'd46, 7'd48, 7'd51, 7'd53, 7'd56, 7'd59
    };

endpackage

// File: rtl/tdoa_angle_est_asin_rom.sv
// Synchronous arcsine ROM: lag magnitude in, unsigned degrees out one cycle later.
// Addresses beyond the table clamp to 90 degrees.
module asin_rom
    import tdoa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] addr_i,
    output logic [6:0] data_o
);

    logic [6:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (addr_i > 5'(MAX_LAG)) begin
            data_q <= 7'd90;
        end else begin
            data_q <= ASIN_LUT[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/tdoa_angle_est.sv
// Captures the correlator's winning lag on each rising edge of finished, smooths it with a
// power-of-two moving average and converts the averaged lag to an arrival angle.
module tdoa_angle_est #(
    parameter int AVG_LOG2 = 2,
    parameter int MAX_LAG  = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              finished,
    input  logic [5:0]        sequence_num,
    output logic signed [6:0] lag_avg,
    output logic signed [7:0] angle_deg,
    output logic              angle_valid,
    output logic [15:0]       frame_cnt,
    output logic              err_range,
    output logic              err_overrun
);

    import tdoa_pkg::*;

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 7 + AVG_LOG2;
    localparam int PW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam int HALF  = (1 << AVG_LOG2) >> 1;
    localparam logic signed [SW:0] LAG_HI = (SW+1)'(MAX_LAG);
    localparam logic signed [SW:0] LAG_LO = -LAG_HI;

    state_e state_q, state_d;

    logic                 finishedDly_q;
    logic signed [6:0]    lag_q;
    logic signed [SW-1:0] sum_q;
    logic signed [6:0]    hist_q [DEPTH];
    logic [PW-1:0]        wptr_q;
    logic [FW-1:0]        fill_q;
    logic signed [6:0]    avg_q;
    logic signed [6:0]    lagAvg_q;
    logic signed [7:0]    angleDeg_q;
    logic                 valid_q;
    logic [15:0]          frameCnt_q;
    logic                 errRange_q;
    logic                 errOverrun_q;

    logic                 finEdge;
    logic                 seqValid;
    logic signed [6:0]    seqLag;
    logic signed [SW-1:0] sumNext;
    logic signed [SW:0]   rounded;
    logic signed [SW:0]   shifted;
    logic signed [6:0]    avgSat;
    logic [4:0]           romAddr;
    logic [6:0]           romData;
    logic                 captureEn, rangeErrEn, accumEn, outEn, overrunEn;

    assign finEdge  = finished & ~finishedDly_q;
    assign seqValid = (sequence_num <= 6'(SEQ_MAX));

    // Indices above MAX_LAG encode negative lags (mic_1 leads).
    always_comb begin
        if (sequence_num <= 6'(MAX_LAG)) begin
            seqLag = $signed({1'b0, sequence_num});
        end else begin
            seqLag = 7'(MAX_LAG) - $signed({1'b0, sequence_num});
        end
    end

    always_comb begin
        sumNext = sum_q + SW'(lag_q) - SW'(hist_q[wptr_q]);
        rounded = (SW+1)'(sumNext) + (SW+1)'(HALF);
        shifted = rounded >>> AVG_LOG2;
        if (shifted > LAG_HI) begin
            avgSat = 7'(MAX_LAG);
        end else if (shifted < LAG_LO) begin
            avgSat = -7'(MAX_LAG);
        end else begin
            avgSat = 7'(shifted);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (finEdge && seqValid) state_d = ACCUM;
            ACCUM:   state_d = LOOKUP;
            LOOKUP:  state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        captureEn  = 1'b0;
        rangeErrEn = 1'b0;
        accumEn    = 1'b0;
        outEn      = 1'b0;
        overrunEn  = 1'b0;
        case (state_q)
            IDLE: begin
                captureEn  = finEdge & seqValid;
                rangeErrEn = finEdge & ~seqValid;
            end
            ACCUM:   accumEn = 1'b1;
            OUT:     outEn   = 1'b1;
            default: ;
        endcase
        if (state_q != IDLE) begin
            overrunEn = finEdge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finishedDly_q <= 1'b0;
            lag_q         <= '0;
            sum_q         <= '0;
            wptr_q        <= '0;
            fill_q        <= '0;
            avg_q         <= '0;
            frameCnt_q    <= '0;
            errRange_q    <= 1'b0;
            errOverrun_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            finishedDly_q <= finished;
            if (captureEn) begin
                lag_q <= seqLag;
            end
            if (rangeErrEn) begin
                errRange_q <= 1'b1;
            end
            if (overrunEn) begin
                errOverrun_q <= 1'b1;
            end
            if (accumEn) begin
                sum_q          <= sumNext;
                hist_q[wptr_q] <= lag_q;
                wptr_q         <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                avg_q          <= avgSat;
                if (fill_q != FW'(DEPTH)) begin
                    fill_q <= fill_q + 1'b1;
                end
                if (frameCnt_q != 16'hFFFF) begin
                    frameCnt_q <= frameCnt_q + 16'd1;
                end
            end
        end
    end

    assign romAddr = 5'(avg_q[6] ? -avg_q : avg_q);

    asin_rom u_asin_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_i (romAddr),
        .data_o (romData)
    );

    // Warm-up frames (history not yet full) leave the published outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lagAvg_q   <= '0;
            angleDeg_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (outEn && fill_q == FW'(DEPTH)) begin
                lagAvg_q   <= avg_q;
                angleDeg_q <= avg_q[6] ? -$signed({1'b0, romData}) : $signed({1'b0, romData});
                valid_q    <= 1'b1;
            end
        end
    end

    assign lag_avg     = lagAvg_q;
    assign angle_deg   = angleDeg_q;
    assign angle_valid = valid_q;
    assign frame_cnt   = frameCnt_q;
    assign err_range   = errRange_q;
    assign err_overrun = errOverrun_q;

endmodule

// File: tb/tb_tdoa_angle_est.sv
// Self-checking bench for tdoa_angle_est: directed scenarios plus random frames checked
// against a queue-based moving-average / arcsine reference model.
module tb_tdoa_angle_est;

    localparam int AVG_LOG2 = 2;
    localparam int DEPTH    = 1 << AVG_LOG2;

    logic              clk;
    logic              rst_n;
    logic              finished;
    logic [5:0]        sequence_num;
    logic signed [6:0] lag_avg;
    logic signed [7:0] angle_deg;
    logic              angle_valid;
    logic [15:0]       frame_cnt;
    logic              err_range;
    logic              err_overrun;

    int testCount = 0;
    int failCount = 0;

    int mHist[$];
    int mFrames;
    int mLag;
    int mAngle;
    bit mErrRange;
    bit mErrOver;

    tdoa_angle_est #(.AVG_LOG2(AVG_LOG2), .MAX_LAG(30)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .finished     (finished),
        .sequence_num (sequence_num),
        .lag_avg      (lag_avg),
        .angle_deg    (angle_deg),
        .angle_valid  (angle_valid),
        .frame_cnt    (frame_cnt),
        .err_range    (err_range),
        .err_overrun  (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int refAngle(input int lag);
        int  mag;
        real x, deg;
        mag = (lag < 0) ? -lag : lag;
        x = real'(mag) * 343.0 / (48000.0 * 0.25);
        if (x >= 1.0) deg = 90.0;
        else          deg = $asin(x) * 180.0 / 3.14159265358979;
        return (lag < 0) ? -$rtoi($floor(deg + 0.5)) : $rtoi($floor(deg + 0.5));
    endfunction

    function automatic bit modelAccept(input int s);
        int lag;
        int sum;
        if (s > 60) begin
            mErrRange = 1'b1;
            return 1'b0;
        end
        lag = (s <= 30) ? s : 30 - s;
        mHist.push_back(lag);
        if (mHist.size() > DEPTH) void'(mHist.pop_front());
        if (mFrames < 65535) mFrames++;
        if (mHist.size() < DEPTH) return 1'b0;
        sum = 0;
        foreach (mHist[i]) sum += mHist[i];
        mLag = $rtoi($floor(real'(sum) / real'(DEPTH) + 0.5));
        if (mLag > 30)  mLag = 30;
        if (mLag < -30) mLag = -30;
        mAngle = refAngle(mLag);
        return 1'b1;
    endfunction

    task automatic modelReset();
        mHist.delete();
        mFrames   = 0;
        mLag      = 0;
        mAngle    = 0;
        mErrRange = 1'b0;
        mErrOver  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_lag"},     lag_avg,     mLag);
        checkOutput({tag, "_angle"},   angle_deg,   mAngle);
        checkOutput({tag, "_frames"},  frame_cnt,   mFrames);
        checkOutput({tag, "_errRng"},  err_range,   mErrRange);
        checkOutput({tag, "_errOvr"},  err_overrun, mErrOver);
    endtask

    // One frame: finished low for a cycle, then high; pulse expected after the 4th posedge.
    task automatic applyStimulus(input string tag, input int s);
        bit expPulse;
        int pulses;
        int pulsePos;
        expPulse = modelAccept(s);
        @(negedge clk);
        finished     = 1'b0;
        sequence_num = 6'(s);
        @(negedge clk);
        finished = 1'b1;
        pulses   = 0;
        pulsePos = -1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (angle_valid) begin
                pulses++;
                pulsePos = k;
            end
        end
        checkOutput({tag, "_pulses"}, pulses, expPulse ? 1 : 0);
        if (expPulse) checkOutput({tag, "_pulsePos"}, pulsePos, 3);
        checkState(tag);
    endtask

    initial begin
        int pulses;
        bit expP;

        modelReset();
        rst_n        = 1'b0;
        finished     = 1'b0;
        sequence_num = '0;
        #1;
        checkState("reset");
        checkOutput("reset_valid", angle_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus("warm", 10);
        checkOutput("warm_lag_const",   lag_avg,   10);
        checkOutput("warm_angle_const", angle_deg, 17);
        checkOutput("warm_frames_const", frame_cnt, 4);

        for (int i = 0; i < 4; i++) applyStimulus("neg40", 40);
        checkOutput("neg40_angle_const", angle_deg, -17);
        for (int i = 0; i < 4; i++) applyStimulus("neg60", 60);
        checkOutput("neg60_lag_const",   lag_avg,   -30);
        checkOutput("neg60_angle_const", angle_deg, -59);

        applyStimulus("alt", 10);
        applyStimulus("alt", 40);
        applyStimulus("alt", 10);
        applyStimulus("alt", 40);
        checkOutput("alt_lag_const", lag_avg, 0);
        applyStimulus("rnd", 1);
        applyStimulus("rnd", 1);
        applyStimulus("rnd", 0);
        applyStimulus("rnd", 0);
        checkOutput("round_lag_const",   lag_avg,   1);
        checkOutput("round_angle_const", angle_deg, 2);

        applyStimulus("range", 63);
        checkOutput("range_flag_const", err_range, 1);
        applyStimulus("after_range", 5);

        // Second edge two clocks after capture lands in LOOKUP and must be dropped.
        expP     = modelAccept(20);
        mErrOver = 1'b1;
        @(negedge clk);
        finished     = 1'b0;
        sequence_num = 6'd20;
        @(negedge clk);
        finished = 1'b1;
        pulses   = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (angle_valid) pulses++;
            if (k == 0) finished = 1'b0;
            if (k == 1) finished = 1'b1;
        end
        checkOutput("overrun_pulses", pulses, expP ? 1 : 0);
        checkState("overrun");

        expP = modelAccept(25);
        @(negedge clk);
        finished     = 1'b0;
        sequence_num = 6'd25;
        @(negedge clk);
        finished = 1'b1;
        pulses   = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (angle_valid) pulses++;
        end
        checkOutput("steady_pulses", pulses, expP ? 1 : 0);
        checkState("steady");

        for (int i = 0; i < 24; i++) applyStimulus("random", int'($urandom_range(0, 63)));

        // Reset while the frame sits in LOOKUP.
        @(negedge clk);
        finished     = 1'b0;
        sequence_num = 6'd12;
        @(negedge clk);
        finished = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b0;
        finished = 1'b0;
        #1;
        modelReset();
        checkState("midreset");
        checkOutput("midreset_valid", angle_valid, 0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (angle_valid) pulses++;
        end
        checkOutput("midreset_pulses", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 50);
        checkOutput("refill_lag_const", lag_avg, -20);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
